// File: rtl/change_dispenser_ctrl.sv
// change_dispenser_ctrl: sequences the 10-unit and 5-unit coin-return hoppers
// for a refund. It checks inventory first, then pulses each solenoid, confirms
// each coin on the exit sensor, and reports done, short-inventory and jam.
module change_dispenser_ctrl #(
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned INV_W       = 6,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             inv_load,
    input  logic [INV_W-1:0] inv10_in,
    input  logic [INV_W-1:0] inv5_in,
    input  logic             clr_fault,
    input  logic             coin_seen,
    output logic             eject_10,
    output logic             eject_5,
    output logic             busy,
    output logic             done,
    output logic             err_short,
    output logic             jam,
    output logic [AMT_W-1:0] paid_out,
    output logic [INV_W-1:0] inv10,
    output logic [INV_W-1:0] inv5
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYC + TIMEOUT_CYC + 1);
    localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
    localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
    localparam logic [AMT_W-1:0] ONE_A = AMT_W'(1);
    localparam logic [INV_W-1:0] ONE_I = INV_W'(1);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DRV10, S_WAIT10, S_DRV5, S_WAIT5, S_DONE, S_FAULT
    } state_t;

    state_t           state;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] n10_r;
    logic [AMT_W-1:0] n5_r;
    logic [CNT_W-1:0] cnt;

    logic [AMT_W-1:0] inv10_ext;
    logic [AMT_W-1:0] inv5_ext;
    logic [AMT_W-1:0] max10;
    logic [AMT_W-1:0] n10_c;
    logic [AMT_W-1:0] n5_c;
    logic             mult5_c;

    // Coin split for the captured remainder: greedy on tens, limited by stock.
    assign inv10_ext = AMT_W'(inv10);
    assign inv5_ext  = AMT_W'(inv5);
    assign max10     = rem / TEN;
    assign n10_c     = (max10 < inv10_ext) ? max10 : inv10_ext;
    assign n5_c      = (rem - n10_c * TEN) / FIVE;
    assign mult5_c   = ((rem % FIVE) == '0);

    // Dispense sequencer; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rem       <= '0;
            n10_r     <= '0;
            n5_r      <= '0;
            cnt       <= '0;
            eject_10  <= 1'b0;
            eject_5   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_short <= 1'b0;
            jam       <= 1'b0;
            paid_out  <= '0;
            inv10     <= '0;
            inv5      <= '0;
        end else begin
            done      <= 1'b0;
            err_short <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inv_load) begin
                        inv10 <= inv10_in;
                        inv5  <= inv5_in;
                    end
                    if (req) begin
                        rem      <= amount;
                        paid_out <= '0;
                        busy     <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!mult5_c || (n5_c > inv5_ext)) begin
                        err_short <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (rem == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        n10_r <= n10_c;
                        n5_r  <= n5_c;
                        cnt   <= '0;
                        if (n10_c != '0) begin
                            eject_10 <= 1'b1;
                            state    <= S_DRV10;
                        end else begin
                            eject_5 <= 1'b1;
                            state   <= S_DRV5;
                        end
                    end
                end
                S_DRV10: begin
                    if (cnt == PULSE_LAST) begin
                        eject_10 <= 1'b0;
                        cnt      <= '0;
                        state    <= S_WAIT10;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                S_DRV5: begin
                    if (cnt == PULSE_LAST) begin
                        eject_5 <= 1'b0;
                        cnt     <= '0;
                        state   <= S_WAIT5;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                S_WAIT10: begin
                    if (coin_seen) begin
                        inv10    <= inv10 - ONE_I;
                        n10_r    <= n10_r - ONE_A;
                        rem      <= rem - TEN;
                        paid_out <= paid_out + TEN;
                        cnt      <= '0;
                        if (n10_r > ONE_A) begin
                            eject_10 <= 1'b1;
                            state    <= S_DRV10;
                        end else if (n5_r != '0) begin
                            eject_5 <= 1'b1;
                            state   <= S_DRV5;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        jam   <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                S_WAIT5: begin
                    if (coin_seen) begin
                        inv5     <= inv5 - ONE_I;
                        n5_r     <= n5_r - ONE_A;
                        rem      <= rem - FIVE;
                        paid_out <= paid_out + FIVE;
                        cnt      <= '0;
                        if (n5_r > ONE_A) begin
                            eject_5 <= 1'b1;
                            state   <= S_DRV5;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        jam   <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    if (inv_load) begin
                        inv10 <= inv10_in;
                        inv5  <= inv5_in;
                    end
                    if (clr_fault) begin
                        jam   <= 1'b0;
                        busy  <= 1'b0;
                        rem   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: each refund is predicted from the coin-split
// rules and the latency formula, then compared cycle by cycle.
module tb_change_dispenser_ctrl;

    localparam int AMT_W = 8;
    localparam int INV_W = 6;
    localparam int PULSE = 4;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic [AMT_W-1:0] amount;
    logic             inv_load;
    logic [INV_W-1:0] inv10_in;
    logic [INV_W-1:0] inv5_in;
    logic             clr_fault;
    logic             coin_seen;
    logic             eject_10;
    logic             eject_5;
    logic             busy;
    logic             done;
    logic             err_short;
    logic             jam;
    logic [AMT_W-1:0] paid_out;
    logic [INV_W-1:0] inv10;
    logic [INV_W-1:0] inv5;

    int n_cmp = 0;
    int n_bad = 0;
    int m_inv10 = 0;
    int m_inv5  = 0;
    int m_paid  = 0;

    change_dispenser_ctrl #(
        .AMT_W(AMT_W), .INV_W(INV_W), .PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .amount(amount), .inv_load(inv_load),
        .inv10_in(inv10_in), .inv5_in(inv5_in), .clr_fault(clr_fault),
        .coin_seen(coin_seen), .eject_10(eject_10), .eject_5(eject_5),
        .busy(busy), .done(done), .err_short(err_short), .jam(jam),
        .paid_out(paid_out), .inv10(inv10), .inv5(inv5)
    );

    always #5 clk = ~clk;

    task automatic check_regs(input string name);
        n_cmp++;
        if (int'(paid_out) !== m_paid || int'(inv10) !== m_inv10 || int'(inv5) !== m_inv5) begin
            n_bad++;
            $display("FAIL %s paid/inv10/inv5 got=%0d/%0d/%0d exp=%0d/%0d/%0d", name,
                     paid_out, inv10, inv5, m_paid, m_inv10, m_inv5);
        end
    endtask

    task automatic load_inv(input int a, input int b);
        @(negedge clk);
        inv_load = 1'b1;
        inv10_in = INV_W'(a);
        inv5_in  = INV_W'(b);
        @(negedge clk);
        inv_load = 1'b0;
        m_inv10  = a;
        m_inv5   = b;
    endtask

    // One refund: predict coin schedule, drive sensor, compare every cycle.
    task automatic run_txn(input string name, input int amt, input int fix_d, input int withhold,
                           input bit with_load, input int ld10, input int ld5, input bit poke);
        int n10, n5, s, d, end_c, last, fault_c, paid_exp, paid10, paid5;
        bit err, fault, e10, e5, bz, cs;
        int cv[$];
        int st[$];
        int cc[$];
        logic [5:0] got, want;
        if (with_load) begin
            m_inv10 = ld10;
            m_inv5  = ld5;
        end
        err = (amt % 5) != 0;
        n10 = (amt / 10 < m_inv10) ? amt / 10 : m_inv10;
        n5  = (amt - 10 * n10) / 5;
        if (n5 > m_inv5) err = 1'b1;
        s = 1; fault = 1'b0; fault_c = 0; paid_exp = 0; paid10 = 0; paid5 = 0;
        if (!err) begin
            for (int i = 0; i < n10 + n5; i++) begin
                cv.push_back(i < n10 ? 10 : 5);
                st.push_back(s);
                if (i == withhold) begin
                    fault   = 1'b1;
                    fault_c = s + PULSE + TMO;
                    break;
                end
                d = (fix_d > 0) ? fix_d : int'($urandom_range(1, 4));
                cc.push_back(s + PULSE + d - 1);
                paid_exp += cv[i];
                if (cv[i] == 10) paid10++; else paid5++;
                s += PULSE + d;
            end
        end
        end_c = err ? 1 : (fault ? fault_c : s);
        last  = end_c + 1;

        @(negedge clk);
        req    = 1'b1;
        amount = AMT_W'(amt);
        if (with_load) begin
            inv_load = 1'b1;
            inv10_in = INV_W'(ld10);
            inv5_in  = INV_W'(ld5);
        end
        @(negedge clk);
        req      = 1'b0;
        inv_load = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            bz = err ? (c == 0) : (fault ? 1'b1 : (c <= end_c));
            e10 = 1'b0;
            e5  = 1'b0;
            foreach (st[i]) begin
                if (c >= st[i] && c < st[i] + PULSE) begin
                    if (cv[i] == 10) e10 = 1'b1; else e5 = 1'b1;
                end
            end
            want = {bz, e10, e5, (!err && !fault && c == end_c), (err && c == 1),
                    (fault && c >= fault_c)};
            got  = {busy, eject_10, eject_5, done, err_short, jam};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s amt=%0d cyc=%0d {busy,ej10,ej5,done,err,jam} got=%b exp=%b",
                         name, amt, c, got, want);
            end
            cs = 1'b0;
            foreach (cc[i]) if (cc[i] == c) cs = 1'b1;
            if ((e10 || e5) && $urandom_range(0, 3) == 0) cs = 1'b1;
            coin_seen = cs;
            req       = poke && bz && (c >= 1) && ($urandom_range(0, 3) == 0);
            amount    = AMT_W'($urandom_range(0, 255));
        end
        coin_seen = 1'b0;
        req       = 1'b0;
        if (err) begin
            m_paid = 0;
        end else begin
            m_paid   = paid_exp;
            m_inv10 -= paid10;
            m_inv5  -= paid5;
        end
        check_regs(name);
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; amount = '0; inv_load = 1'b0; inv10_in = '0;
        inv5_in = '0; clr_fault = 1'b0; coin_seen = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, eject_10, eject_5, done, err_short, jam} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset flags got=%b exp=000000",
                     {busy, eject_10, eject_5, done, err_short, jam});
        end
        check_regs("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        load_inv(3, 2);
        run_txn("basic25", 25, 2, -1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_short();
        load_inv(1, 1);
        run_txn("short25", 25, 0, -1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_bad_amount();
        run_txn("amt7", 7, 0, -1, 1'b0, 0, 0, 1'b0);
        run_txn("amt0", 0, 0, -1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_only5();
        load_inv(0, 4);
        run_txn("only5", 15, 0, -1, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_jam();
        load_inv(3, 2);
        run_txn("jam20", 20, 0, 1, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        n_cmp++;
        if ({busy, jam, eject_10, eject_5} !== 4'b0) begin
            n_bad++;
            $display("FAIL clr_fault {busy,jam,ej10,ej5} got=%b exp=0000",
                     {busy, jam, eject_10, eject_5});
        end
        check_regs("after_clr");
        run_txn("post_jam10", 10, 0, -1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        load_inv(3, 3);
        @(negedge clk);
        req = 1'b1;
        amount = AMT_W'(20);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (eject_10 !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_drv eject_10 got=%b exp=1", eject_10);
        end
        #2 rst = 1'b0;
        #1;
        m_inv10 = 0; m_inv5 = 0; m_paid = 0;
        n_cmp++;
        if ({busy, eject_10, eject_5, done, err_short, jam} !== 6'b0) begin
            n_bad++;
            $display("FAIL midrst flags got=%b exp=000000",
                     {busy, eject_10, eject_5, done, err_short, jam});
        end
        check_regs("midrst");
        @(negedge clk);
        rst = 1'b1;
        coin_seen = 1'b1;
        @(negedge clk);
        coin_seen = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, eject_10, eject_5, done, err_short, jam} !== 6'b0) begin
            n_bad++;
            $display("FAIL stray_coin flags got=%b exp=000000",
                     {busy, eject_10, eject_5, done, err_short, jam});
        end
        check_regs("stray_coin");
    endtask

    task automatic test_back_to_back();
        run_txn("load_req", 35, 0, -1, 1'b1, 2, 5, 1'b1);
        run_txn("b2b", 10, 1, -1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int mode, amt;
        for (int it = 0; it < 25; it++) begin
            mode = int'($urandom_range(0, 2));
            amt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : 5 * int'($urandom_range(0, 16));
            if (mode == 0) load_inv(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
            run_txn("rand", amt, 0, -1, mode == 1, int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 8)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_bad_amount();
        test_only5();
        test_jam();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser_ctrl.md
Name: change_dispenser_ctrl

Overview:
- Sequences the two coin-return hoppers (10-unit and 5-unit) when the vending FSM issues a refund or change amount.
- Checks inventory before any coin moves, drives each hopper solenoid with timed pulses, and confirms every coin on the exit sensor.
- Tracks hopper inventory and reports done, short-inventory and jam conditions back to the vending FSM.

Parameters:
- AMT_W, 8, width of the amount and paid-out values.
- INV_W, 6, width of each hopper inventory counter.
- PULSE_CYC, 4, cycles the eject solenoid is held high per coin.
- TIMEOUT_CYC, 16, cycles allowed after the pulse ends for coin_seen before a jam is declared.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  one-cycle refund request; sampled only in IDLE.
- amount  in  AMT_W  refund value, captured with req.
- inv_load  in  1  load both inventories from inv10_in/inv5_in; honoured only in IDLE or FAULT.
- inv10_in  in  INV_W  refill count for the 10-unit hopper.
- inv5_in  in  INV_W  refill count for the 5-unit hopper.
- clr_fault  in  1  leave FAULT and return to IDLE.
- coin_seen  in  1  exit sensor; one-cycle pulse per coin.
- eject_10  out  1  10-unit hopper solenoid drive.
- eject_5  out  1  5-unit hopper solenoid drive.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the refund completes.
- err_short  out  1  one-cycle pulse on a rejected request.
- jam  out  1  level output; high while in FAULT.
- paid_out  out  AMT_W  value dispensed in the current or last transaction.
- inv10  out  INV_W  current 10-unit hopper inventory.
- inv5  out  INV_W  current 5-unit hopper inventory.

Behaviour:
- Reset, when rst is low (async): state IDLE; all outputs 0; inv10/inv5 = 0; internal remaining count = 0.
- States: IDLE, CHECK, DRV10, WAIT10, DRV5, WAIT5, DONE, FAULT.
- IDLE:
  - req=1 captures amount into rem, clears paid_out, and goes to CHECK.
  - req is ignored in every other state.
  - If req and inv_load arrive in the same cycle, inv_load is applied first and CHECK uses the new inventory.
- CHECK (one cycle):
  - amount not a multiple of 5: err_short pulse, go to IDLE.
  - Otherwise compute n10 = min(rem/10, inv10) and n5 = (rem - 10*n10)/5.
  - n5 > inv5: err_short pulse, go to IDLE, no coin moved.
  - rem == 0: go to DONE.
  - Else go to DRV10 if n10 > 0, otherwise DRV5.
- DRV10 / DRV5:
  - eject_10 or eject_5 is high for exactly PULSE_CYC cycles, then go to WAIT10 or WAIT5.
  - The two eject outputs are never high in the same cycle.
- WAIT10 / WAIT5:
  - coin_seen within TIMEOUT_CYC cycles: decrement the inventory by 1, decrement n10 or n5, subtract 10 or 5 from rem, add 10 or 5 to paid_out.
  - Next state: DRV10 if n10 > 0, else DRV5 if n5 > 0, else DONE.
  - Timeout: go to FAULT. rem, paid_out and inventory stay unchanged.
- coin_seen outside the WAIT states is ignored.
- DONE: done pulse for one cycle, then IDLE. paid_out holds until the next accepted req.
- FAULT:
  - jam=1, eject outputs 0.
  - clr_fault goes to IDLE. The unpaid remainder is dropped; paid_out reports the partial payout.
- Arithmetic: paid_out and rem are exact. amount ≤ 2^AMT_W−1, so no overflow. Inventory never decrements below 0 because of the CHECK guarantee.
- Mid-operation reset: immediate return to IDLE. Inventory is cleared and must be reloaded.
- Latency for a refund of k coins, each seen d cycles after its pulse: 1 (CHECK) + k·(PULSE_CYC + d) + 1 (DONE) cycles from the req cycle.

Test Plan:
1. Load inv10=3, inv5=2, req amount=25 → two eject_10 pulses then one eject_5 pulse (each 4 cycles); coin_seen 2 cycles after each pulse → done, paid_out=25, inv10=1, inv5=1.
2. inv10=1, inv5=1, amount=25 → err_short pulse one cycle after req; no eject activity; inventory unchanged.
3. amount=7 → err_short; amount=0 → done 2 cycles after req, paid_out=0.
4. inv10=0, inv5=4, amount=15 → three eject_5 pulses, done, inv5=1.
5. amount=20 with coin_seen withheld after the 2nd 10-coin pulse → jam asserted 16 cycles after that pulse ends, paid_out=10; clr_fault → IDLE; a new req is accepted.
6. Deassert rst during DRV10 → all outputs 0 immediately; req while busy and stray coin_seen in IDLE produce no effect.
